byte_matrix_deserialiser: RTL

Receive-side counterpart of Concat_Serialiser_TOP. Accepts a byte stream, one byte per cycle, over a valid/ready handshake and packs it into a ChaCha20-style 4x4 matrix of 32-bit words. Packing is little-endian per word, row-major. Sits in front of the ChaCha20 XOR / Poly1305 datapath to turn incoming plaintext or AAD bytes into 64-byte blocks. Short final blocks are zero-padded and tagged with their byte count.

---
 rtl/chacha_pkg.sv | 35 +++
 rtl/block_fill_buffer.sv | 60 ++++++
 rtl/byte_matrix_deserialiser.sv | 133 +++++++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// Shared types for the ChaCha20 byte-to-matrix front end.
//   word_t      : one 32-bit matrix word
//   matrix_t    : 4x4 words, [row][col]
//   byte_pos()  : maps stream byte index 0..63 to row/col/byte-lane
//   out_state_e : occupancy of the deserialiser output side
package chacha_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [3:0][3:0] matrix_t;

  localparam int BYTES_PER_BLOCK = 64;
  localparam int WORDS_PER_BLOCK = 16;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
    logic [1:0] lane;
  } byte_pos_t;

  // Row-major word order, little-endian bytes within each word.
  function automatic byte_pos_t byte_pos(input logic [5:0] k);
    byte_pos_t p;
    p.row  = k[5:4];
    p.col  = k[3:2];
    p.lane = k[1:0];
    return p;
  endfunction

  typedef enum logic [1:0] {
    OUT_EMPTY,
    OUT_FULL,
    OUT_FULL_PENDING
  } out_state_e;

endpackage

// File: rtl/block_fill_buffer.sv
// Collect buffer for one 64-byte block.
//   wr_en/wr_data : write one byte at the current fill position
//   clr           : empty the buffer (wins over wr_en; the byte being
//                   written that cycle travels on via mat_nxt_o)
//   mat_o         : registered buffer contents
//   mat_nxt_o     : buffer contents with wr_data merged at the fill position
//   cnt_o         : bytes held, 0..64
module block_fill_buffer
  import chacha_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       clr,
  output matrix_t    mat_o,
  output matrix_t    mat_nxt_o,
  output logic [6:0] cnt_o
);

  matrix_t    mat_q, mat_d, mat_wr;
  logic [6:0] cnt_q, cnt_d;
  byte_pos_t  pos;

  always_comb begin
    pos    = byte_pos(cnt_q[5:0]);
    mat_wr = mat_q;
    // Byte-lane write enable: exactly one lane matches the fill position.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        for (int l = 0; l < 4; l++)
          if (pos.row == 2'(r) && pos.col == 2'(c) && pos.lane == 2'(l))
            mat_wr[r][c][8*l +: 8] = wr_data;

    mat_d = mat_q;
    cnt_d = cnt_q;
    if (clr) begin
      mat_d = '0;
      cnt_d = '0;
    end else if (wr_en) begin
      mat_d = mat_wr;
      cnt_d = cnt_q + 7'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_q <= '0;
      cnt_q <= '0;
    end else begin
      mat_q <= mat_d;
      cnt_q <= cnt_d;
    end
  end

  assign mat_o     = mat_q;
  assign mat_nxt_o = mat_wr;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/byte_matrix_deserialiser.sv
// Byte stream -> 4x4 matrix of 32-bit words (64-byte blocks).
//   in_valid/in_ready/in_data/in_last : byte stream, in_last ends a message
//   out_valid/out_ready               : block handshake
//   out_data                          : assembled matrix, short blocks zero-padded
//   out_len                           : valid bytes in out_data, 1..64
//   out_last                          : block ends the message
// A finished block moves straight to the output register when it is free
// (or draining that cycle); otherwise it parks in the collect buffer and
// input is stalled until the output register drains.
module byte_matrix_deserialiser
  import chacha_pkg::*;
#(
  parameter int DATA_SIZE       = 8,
  parameter int BYTES_PER_BLOCK = 64,
  parameter int LEN_W           = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output matrix_t              out_data,
  output logic [LEN_W-1:0]     out_len,
  output logic                 out_last
);

  if (DATA_SIZE != 8) begin : g_bad_data_size
    $error("byte_matrix_deserialiser: DATA_SIZE must be 8");
  end
  if (BYTES_PER_BLOCK != chacha_pkg::BYTES_PER_BLOCK) begin : g_bad_block
    $error("byte_matrix_deserialiser: BYTES_PER_BLOCK must be 64");
  end
  if (LEN_W < 7) begin : g_bad_len_w
    $error("byte_matrix_deserialiser: LEN_W must hold 64");
  end

  out_state_e       state_q, state_d;
  matrix_t          out_data_q, out_data_d;
  logic [LEN_W-1:0] out_len_q, out_len_d;
  logic             out_last_q, out_last_d;
  logic             pend_last_q, pend_last_d;

  matrix_t    fb_mat, fb_mat_nxt;
  logic [6:0] fb_cnt;
  logic       fb_clr;
  logic       in_fire, complete, drain;

  assign in_ready  = (state_q != OUT_FULL_PENDING);
  assign out_valid = (state_q != OUT_EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign complete  = in_fire && (fb_cnt == 7'd63 || in_last);
  assign drain     = out_valid && out_ready;

  block_fill_buffer u_fill (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (in_fire),
    .wr_data   (in_data),
    .clr       (fb_clr),
    .mat_o     (fb_mat),
    .mat_nxt_o (fb_mat_nxt),
    .cnt_o     (fb_cnt)
  );

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_len_d   = out_len_q;
    out_last_d  = out_last_q;
    pend_last_d = pend_last_q;
    fb_clr      = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (complete) begin
          out_data_d = fb_mat_nxt;
          out_len_d  = LEN_W'(fb_cnt + 7'd1);
          out_last_d = in_last;
          fb_clr     = 1'b1;
          state_d    = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (complete && drain) begin
          out_data_d = fb_mat_nxt;
          out_len_d  = LEN_W'(fb_cnt + 7'd1);
          out_last_d = in_last;
          fb_clr     = 1'b1;
        end else if (complete) begin
          // Last byte is written into the collect buffer; count becomes the length.
          pend_last_d = in_last;
          state_d     = OUT_FULL_PENDING;
        end else if (drain) begin
          state_d = OUT_EMPTY;
        end
      end
      OUT_FULL_PENDING: begin
        if (drain) begin
          out_data_d  = fb_mat;
          out_len_d   = LEN_W'(fb_cnt);
          out_last_d  = pend_last_q;
          pend_last_d = 1'b0;
          fb_clr      = 1'b1;
          state_d     = OUT_FULL;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OUT_EMPTY;
      out_data_q  <= '0;
      out_len_q   <= '0;
      out_last_q  <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
      out_last_q  <= out_last_d;
      pend_last_q <= pend_last_d;
    end
  end

  assign out_data = out_data_q;
  assign out_len  = out_len_q;
  assign out_last = out_last_q;

endmodule
